// File: rtl/read_controller_sdram_pkg.sv
// Shared definitions for the SDRAM pixel read path: frame-region boundary,
// burst index width and fill-FSM state encodings, common with the write controller.
package read_controller_sdram_pkg;

    localparam int DEF_FRAME_WIDTH  = 640;
    localparam int DEF_FRAME_HEIGHT = 480;
    localparam int DEF_BURST_LEN    = 8;
    localparam int DEF_PIXEL_W      = 16;
    localparam int DEF_ADDR_W       = 24;

    localparam int FRAME_BOUNDARY = DEF_FRAME_WIDTH * DEF_FRAME_HEIGHT * 2;
    localparam int BURST_IDX_W    = $clog2(DEF_BURST_LEN);

    typedef enum logic [1:0] {
        FILL_IDLE  = 2'd0,
        FILL_REQ   = 2'd1,
        FILL_RECV  = 2'd2,
        FILL_DRAIN = 2'd3
    } fill_state_e;

    // Word count of the frame region shared by the writer and this reader.
    function automatic int frame_boundary(input int width, input int height);
        return width * height * 2;
    endfunction

endpackage

// File: rtl/read_controller_sdram_burst_buffer.sv
// Ping-pong burst storage: 2 x BurstLen words, one write port, one registered
// read port whose output holds when no read is issued.
module sdram_burst_buffer
    import read_controller_sdram_pkg::*;
#(
    parameter int BurstLen = DEF_BURST_LEN,
    parameter int PixelW   = DEF_PIXEL_W,
    parameter int IdxW     = BURST_IDX_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              wr_en_i,
    input  logic              wr_sel_i,
    input  logic [IdxW-1:0]   wr_idx_i,
    input  logic [PixelW-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic              rd_sel_i,
    input  logic [IdxW-1:0]   rd_idx_i,
    output logic [PixelW-1:0] rd_data_o
);

    logic [PixelW-1:0] mem_q [2*BurstLen];
    logic [PixelW-1:0] rd_data_q;
    logic [IdxW:0]     wr_addr;
    logic [IdxW:0]     rd_addr;

    assign wr_addr   = {wr_sel_i, wr_idx_i};
    assign rd_addr   = {rd_sel_i, rd_idx_i};
    assign rd_data_o = rd_data_q;

    always_ff @(posedge CLK) begin
        if (wr_en_i) begin
            mem_q[wr_addr] <= wr_data_i;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

endmodule

// File: rtl/read_controller_sdram.sv
// SDRAM burst reader feeding the VGA pixel pipeline through a ping-pong buffer.
// Optional SDRAM_RD_STATS_EN adds a saturating 16-bit underrun counter output.
module read_controller_sdram
    import read_controller_sdram_pkg::*;
#(
    parameter int FrameWidth        = DEF_FRAME_WIDTH,
    parameter int FrameHeight       = DEF_FRAME_HEIGHT,
    parameter int BurstLengthSDRAM  = DEF_BURST_LEN,
    parameter int PixelBitWidth     = DEF_PIXEL_W,
    parameter int AddressWidthSDRAM = DEF_ADDR_W
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         i_frame_start,
    input  logic                         i_read_req,
    input  logic                         i_sdram_valid_rd,
    input  logic [PixelBitWidth-1:0]     i_sdram_pixel,
    output logic                         o_sdram_rd_req,
    output logic [AddressWidthSDRAM-1:0] o_sdram_addr,
    output logic [PixelBitWidth-1:0]     o_pixel,
    output logic                         o_pixel_valid,
    output logic                         o_underrun,
    output logic                         o_busy_rd
`ifdef SDRAM_RD_STATS_EN
    ,
    output logic [15:0]                  o_underrun_count
`endif
);

    localparam int Boundary = frame_boundary(FrameWidth, FrameHeight);
    localparam int IdxW     = $clog2(BurstLengthSDRAM);
    localparam int HeadW    = $clog2(Boundary);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(BurstLengthSDRAM - 1);

    fill_state_e                  state_q, state_d;
    logic [HeadW-1:0]             head_q, head_d;
    logic [HeadW:0]               head_adv;
    logic [AddressWidthSDRAM-1:0] addr_q, addr_d;
    logic [IdxW-1:0]              wr_idx_q, wr_idx_d;
    logic [IdxW-1:0]              rd_idx_q, rd_idx_d;
    logic [1:0]                   full_q, full_d;
    logic                         fill_sel_q, fill_sel_d;
    logic                         rd_sel_q, rd_sel_d;
    logic                         rd_req_q, pixel_valid_q, underrun_q;
    logic                         rd_hit, underrun_event, buf_wr_en;

    assign head_adv       = {1'b0, head_q} + (HeadW+1)'(BurstLengthSDRAM);
    assign rd_hit         = i_read_req && full_q[rd_sel_q] && !i_frame_start;
    assign underrun_event = i_read_req && !rd_hit;

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        addr_d     = addr_q;
        wr_idx_d   = wr_idx_q;
        rd_idx_d   = rd_idx_q;
        full_d     = full_q;
        fill_sel_d = fill_sel_q;
        rd_sel_d   = rd_sel_q;
        buf_wr_en  = 1'b0;

        if (rd_hit) begin
            rd_idx_d = rd_idx_q + 1'b1;
            if (rd_idx_q == LastIdx) begin
                full_d[rd_sel_q] = 1'b0;
                rd_sel_d         = ~rd_sel_q;
                rd_idx_d         = '0;
            end
        end

        case (state_q)
            FILL_IDLE: begin
                if (!full_q[fill_sel_q]) begin
                    state_d = FILL_REQ;
                    addr_d  = AddressWidthSDRAM'(head_q);
                end
            end
            FILL_REQ: begin
                if (i_sdram_valid_rd) begin
                    buf_wr_en = 1'b1;
                    wr_idx_d  = IdxW'(1);
                    state_d   = FILL_RECV;
                end
            end
            FILL_RECV: begin
                if (i_sdram_valid_rd) begin
                    buf_wr_en = 1'b1;
                    wr_idx_d  = wr_idx_q + 1'b1;
                    if (wr_idx_q == LastIdx) begin
                        full_d[fill_sel_q] = 1'b1;
                        fill_sel_d         = ~fill_sel_q;
                        head_d             = (head_adv == (HeadW+1)'(Boundary)) ? '0 : head_adv[HeadW-1:0];
                        wr_idx_d           = '0;
                        state_d            = FILL_IDLE;
                    end
                end
            end
            FILL_DRAIN: begin
                if (i_sdram_valid_rd) begin
                    wr_idx_d = wr_idx_q + 1'b1;
                    if (wr_idx_q == LastIdx) begin
                        wr_idx_d = '0;
                        head_d   = '0;
                        state_d  = FILL_IDLE;
                    end
                end
            end
            default: state_d = FILL_IDLE;
        endcase

        // Frame start overrides everything; a burst already delivering words
        // must still be counted out before the next request can be issued.
        if (i_frame_start) begin
            full_d     = '0;
            fill_sel_d = 1'b0;
            rd_sel_d   = 1'b0;
            rd_idx_d   = '0;
            head_d     = '0;
            buf_wr_en  = 1'b0;
            if (state_q == FILL_IDLE || state_q == FILL_REQ) begin
                state_d  = FILL_IDLE;
                wr_idx_d = '0;
            end else if (state_q == FILL_RECV) begin
                if (i_sdram_valid_rd && wr_idx_q == LastIdx) begin
                    state_d  = FILL_IDLE;
                    wr_idx_d = '0;
                end else begin
                    state_d  = FILL_DRAIN;
                    wr_idx_d = wr_idx_q + IdxW'(i_sdram_valid_rd);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q       <= FILL_IDLE;
            head_q        <= '0;
            addr_q        <= '0;
            wr_idx_q      <= '0;
            rd_idx_q      <= '0;
            full_q        <= '0;
            fill_sel_q    <= 1'b0;
            rd_sel_q      <= 1'b0;
            rd_req_q      <= 1'b0;
            pixel_valid_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            head_q        <= head_d;
            addr_q        <= addr_d;
            wr_idx_q      <= wr_idx_d;
            rd_idx_q      <= rd_idx_d;
            full_q        <= full_d;
            fill_sel_q    <= fill_sel_d;
            rd_sel_q      <= rd_sel_d;
            rd_req_q      <= (state_d == FILL_REQ);
            pixel_valid_q <= rd_hit;
            underrun_q    <= underrun_event;
        end
    end

    sdram_burst_buffer #(
        .BurstLen (BurstLengthSDRAM),
        .PixelW   (PixelBitWidth),
        .IdxW     (IdxW)
    ) u_buffer (
        .CLK       (CLK),
        .RST       (RST),
        .wr_en_i   (buf_wr_en),
        .wr_sel_i  (fill_sel_q),
        .wr_idx_i  (wr_idx_q),
        .wr_data_i (i_sdram_pixel),
        .rd_en_i   (rd_hit),
        .rd_sel_i  (rd_sel_q),
        .rd_idx_i  (rd_idx_q),
        .rd_data_o (o_pixel)
    );

`ifdef SDRAM_RD_STATS_EN
    logic [15:0] uf_count_q;

    always_ff @(posedge CLK) begin
        if (!RST || i_frame_start) begin
            uf_count_q <= '0;
        end else if (underrun_event && uf_count_q != 16'hFFFF) begin
            uf_count_q <= uf_count_q + 16'd1;
        end
    end

    assign o_underrun_count = uf_count_q;
`endif

    assign o_sdram_rd_req = rd_req_q;
    assign o_sdram_addr   = addr_q;
    assign o_pixel_valid  = pixel_valid_q;
    assign o_underrun     = underrun_q;
    assign o_busy_rd      = (state_q != FILL_IDLE);

endmodule

// File: doc/read_controller_sdram.md
Name: read_controller_sdram

Overview:
- Read-side counterpart of the SDRAM pixel write path.
- Fetches fixed-length bursts of pixels from SDRAM, starting at frame address 0 and advancing by one burst each time, into a two-entry (ping-pong) burst buffer.
- Serves one pixel per request to the VGA scan-out side.
- Sits between the SDRAM controller's read port and the VGA pixel pipeline; resynchronises to address 0 at each frame start.

Parameters:
- FrameWidth, 640, active pixels per line
- FrameHeight, 480, active lines per frame
- BurstLengthSDRAM, 8, pixels per SDRAM burst (power of two, >=2)
- PixelBitWidth, 16, bits per pixel
- AddressWidthSDRAM, 24, SDRAM word-address width

Ports:
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  reset, synchronous, active-low
- i_frame_start  in  1  one-cycle pulse: restart fetching at address 0
- i_read_req  in  1  consumer requests the next pixel
- i_sdram_valid_rd  in  1  SDRAM read-data strobe, one word per high cycle
- i_sdram_pixel  in  PixelBitWidth  SDRAM read data
- o_sdram_rd_req  out  1  burst read request
- o_sdram_addr  out  AddressWidthSDRAM  burst start address
- o_pixel  out  PixelBitWidth  pixel returned to consumer
- o_pixel_valid  out  1  o_pixel valid this cycle
- o_underrun  out  1  one-cycle pulse: request arrived with no full buffer
- o_busy_rd  out  1  fill FSM not IDLE

Behaviour:
- Reset values: all outputs 0; head address 0; both buffer-full flags 0; fill select 0; read select 0; all indices 0; fill FSM IDLE.
- Boundary: FrameWidth*FrameHeight*2, the same frame region the writer fills.
  - Head address advances by BurstLengthSDRAM per burst.
  - When the advanced value equals the boundary, it wraps to 0.
  - Internal head is zero-extended onto o_sdram_addr.
- Fill FSM states: IDLE, REQ, RECV, DRAIN.
  - IDLE: if full[fill_sel]==0, go to REQ, drive o_sdram_addr=head and o_sdram_rd_req=1.
  - REQ: hold o_sdram_rd_req and the address until the first i_sdram_valid_rd. On that cycle:
    - store the word at index 0;
    - drop o_sdram_rd_req the next cycle;
    - go to RECV.
  - RECV: each valid stores the word at the next index (gaps allowed). On the final word (index BurstLengthSDRAM-1):
    - set full[fill_sel];
    - toggle fill_sel;
    - advance head, with wrap;
    - go to IDLE.
  - DRAIN: discard valid words until the in-flight burst completes, then go to IDLE with head=0.
- Read side:
  - On i_read_req with full[rd_sel]==1: o_pixel is the buffer word at rd_idx, o_pixel_valid=1 on the next cycle (latency 1); rd_idx increments.
  - On the last index: clear full[rd_sel], toggle rd_sel, and set rd_idx=0.
  - On i_read_req with full[rd_sel]==0: o_pixel_valid=0, o_underrun=1 for 1 cycle, o_pixel holds its previous value.
- Setting a full flag and clearing the other flag in the same cycle are independent and both take effect. The fill side only targets an empty buffer and the read side only reads a full one, so they never address the same entry.
- i_frame_start has priority over all other events in its cycle:
  - both full flags, fill_sel, rd_sel and rd_idx are cleared;
  - a same-cycle i_read_req underruns;
  - from IDLE or REQ (no data received yet): head=0, o_sdram_rd_req=0, FSM to IDLE;
  - from RECV: FSM to DRAIN, o_sdram_rd_req=0;
  - in DRAIN: no additional effect.
- Reset mid-burst returns all state to reset values. The SDRAM controller is reset by the same RST.

Optional Feature:
- Macro: SDRAM_RD_STATS_EN.
- Defined: adds output o_underrun_count, 16 bits.
  - Saturating count of underrun events.
  - Cleared by RST and by i_frame_start; a same-cycle underrun is not counted.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - boundary localparam (FrameWidth*FrameHeight*2);
  - burst index width ($clog2(BurstLengthSDRAM));
  - fill-FSM state encodings;
  - default frame and pixel parameters, shared with the write controller.
- One sub-module, sdram_burst_buffer: 2 x BurstLengthSDRAM x PixelBitWidth storage with one write port (select, index, data) and one registered read port.

Test Plan:
- Reset, then i_read_req=1 → o_underrun pulses, o_pixel_valid=0, o_sdram_rd_req=1 with addr 0.
- SDRAM returns 0x0000..0x0007, then 0x0008..0x000F with 2-cycle gaps → second request at addr 8 and third at addr 16; continuous reads give 0x0000..0x000F in order, one cycle after each request, with no underrun.
- Run to the last burst before the boundary at default size (addr 614392) → next request addr 0.
- i_frame_start after 3 words of a burst → remaining 5 words discarded, next request addr 0, both buffers empty.
- Reads at one per cycle against SDRAM returning one word every 2 cycles → o_underrun pulses; with SDRAM_RD_STATS_EN, o_underrun_count equals the pulse count, saturates at 65535 and clears on i_frame_start.
- RST low mid-RECV → all outputs 0 the next cycle; after release the first request is at addr 0.
